// File: rtl/crc32_pkg.sv
// rtl/crc32_pkg.sv - shared CRC32 constants and controller state encoding
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY   = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } crc_state_t;

endpackage

// File: rtl/crc32_byte_step.sv
// rtl/crc32_byte_step.sv - one reflected CRC32 byte update, passes crc_in through when disabled
module crc32_byte_step
  import crc32_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_byte,
  input  logic        enable,
  output logic [31:0] crc_out
);

  logic [31:0] stepped;

  always_comb begin
    stepped = crc_in ^ {24'h0, data_byte};
    for (int i = 0; i < 8; i++) begin
      stepped = stepped[0] ? ((stepped >> 1) ^ CRC32_POLY) : (stepped >> 1);
    end
    crc_out = enable ? stepped : crc_in;
  end

endmodule

// File: rtl/crc32_stream.sv
// rtl/crc32_stream.sv - streaming gzip CRC32 + ISIZE over DATA_BYTES-wide beats with held result
module crc32_stream
  import crc32_pkg::*;
#(
  parameter int DATA_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    crc_start,
  input  logic [8*DATA_BYTES-1:0] data_in,
  input  logic [DATA_BYTES-1:0]   data_keep,
  input  logic                    data_last,
  input  logic                    data_valid_in,
  output logic                    data_ready_out,
  output logic [31:0]             crc_out,
  output logic [31:0]             isize_out,
  output logic                    crc_valid_out,
  input  logic                    crc_ready_in
);

  crc_state_t state_q, state_base, state_d;
  logic [31:0] crc_q, crc_base;
  logic [31:0] cnt_q, cnt_base, cnt_sum;
  logic [3:0]  n_bytes;
  logic        accept;
  logic [DATA_BYTES-1:0] byte_en;
  logic [31:0] chain [0:DATA_BYTES];

  assign accept = data_valid_in & data_ready_out;

  // crc_start acts before the beat on the same edge, so the beat folds into a fresh message.
  always_comb begin
    state_base = crc_start ? ST_IDLE : state_q;
    crc_base   = crc_start ? CRC32_INIT : crc_q;
    cnt_base   = crc_start ? 32'd0 : cnt_q;
  end

  always_comb begin
    byte_en = '0;
    n_bytes = 4'd0;
    for (int k = 0; k < DATA_BYTES; k++) begin
      byte_en[k] = accept & (~data_last | data_keep[k]);
      n_bytes    = n_bytes + {3'd0, byte_en[k]};
    end
    cnt_sum = cnt_base + {28'd0, n_bytes};
  end

  always_comb begin
    state_d = state_base;
    if (accept) begin
      state_d = data_last ? ST_DONE : ST_ACCUM;
    end else if (state_base == ST_DONE && crc_ready_in) begin
      state_d = ST_IDLE;
    end
  end

  assign chain[0] = crc_base;

  for (genvar g = 0; g < DATA_BYTES; g++) begin : g_step
    crc32_byte_step u_step (
      .crc_in    (chain[g]),
      .data_byte (data_in[8*g +: 8]),
      .enable    (byte_en[g]),
      .crc_out   (chain[g+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      crc_q          <= CRC32_INIT;
      cnt_q          <= 32'd0;
      crc_out        <= 32'd0;
      isize_out      <= 32'd0;
      crc_valid_out  <= 1'b0;
      data_ready_out <= 1'b0;
    end else begin
      state_q        <= state_d;
      data_ready_out <= (state_d != ST_DONE);
      crc_valid_out  <= (state_d == ST_DONE);
      if (crc_start) begin
        crc_out   <= 32'd0;
        isize_out <= 32'd0;
      end
      // The running state rewinds as soon as the result is captured, ready for the next message.
      if (accept && data_last) begin
        crc_q     <= CRC32_INIT;
        cnt_q     <= 32'd0;
        crc_out   <= chain[DATA_BYTES] ^ CRC32_XOROUT;
        isize_out <= cnt_sum;
      end else if (accept) begin
        crc_q <= chain[DATA_BYTES];
        cnt_q <= cnt_sum;
      end else begin
        crc_q <= crc_base;
        cnt_q <= cnt_base;
      end
    end
  end

endmodule

// File: tb/tb_crc32_stream.sv
// tb/tb_crc32_stream.sv - self-checking bench for crc32_stream at widths 1, 4 and 8
module tb_crc32_stream;

  logic        clk = 1'b0;
  logic        rst_n, crc_start, data_last, crc_ready_in;
  logic [63:0] din;
  logic [7:0]  keep;
  logic        dvalid [3];
  logic        rdy_o  [3];
  logic        vld_o  [3];
  logic [31:0] crc_o  [3];
  logic [31:0] isz_o  [3];

  int checks = 0;
  int errors = 0;

  bit [7:0]  msg_q[$];
  bit [31:0] tbl [256];

  typedef struct {
    string       msg;
    logic [31:0] crc;
    logic [31:0] isize;
  } vec_t;
  vec_t vecs [5];

  always #5 clk = ~clk;

  crc32_stream #(.DATA_BYTES(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .crc_start(crc_start), .data_in(din[7:0]), .data_keep(keep[0:0]),
    .data_last(data_last), .data_valid_in(dvalid[0]), .data_ready_out(rdy_o[0]), .crc_out(crc_o[0]),
    .isize_out(isz_o[0]), .crc_valid_out(vld_o[0]), .crc_ready_in(crc_ready_in));

  crc32_stream #(.DATA_BYTES(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .crc_start(crc_start), .data_in(din[31:0]), .data_keep(keep[3:0]),
    .data_last(data_last), .data_valid_in(dvalid[1]), .data_ready_out(rdy_o[1]), .crc_out(crc_o[1]),
    .isize_out(isz_o[1]), .crc_valid_out(vld_o[1]), .crc_ready_in(crc_ready_in));

  crc32_stream #(.DATA_BYTES(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .crc_start(crc_start), .data_in(din), .data_keep(keep),
    .data_last(data_last), .data_valid_in(dvalid[2]), .data_ready_out(rdy_o[2]), .crc_out(crc_o[2]),
    .isize_out(isz_o[2]), .crc_valid_out(vld_o[2]), .crc_ready_in(crc_ready_in));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int width_of(input int sel);
    return (sel == 0) ? 1 : ((sel == 1) ? 4 : 8);
  endfunction

  // Byte-at-a-time table lookup over the whole message.
  function automatic logic [31:0] ref_crc();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (msg_q[i]) c = tbl[(c ^ {24'h0, msg_q[i]}) & 32'hFF] ^ (c >> 8);
    return ~c;
  endfunction

  task automatic load_str(input string s);
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(8'(s[i]));
  endtask

  task automatic drive_beat(input int sel, input logic [63:0] d, input logic [7:0] k,
                            input logic l, input logic st);
    int n;
    n = 0;
    din  = d;
    keep = k;
    data_last = l;
    dvalid[sel] = 1'b1;
    while (!rdy_o[sel] && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout sel=%0d ready=0 required=1", sel);
    end
    if (l) chk($sformatf("valid_before_last_w%0d", width_of(sel)), {31'd0, vld_o[sel]}, 32'd0);
    crc_start = st;
    tick();
    crc_start = 1'b0;
    dvalid[sel] = 1'b0;
    data_last = 1'b0;
  endtask

  task automatic send_msg(input int sel, input bit gaps, input bit start_first,
                          input logic [31:0] exp_crc, input logic [31:0] exp_isz, input string name);
    int w, n, nb;
    logic [63:0] d;
    logic [7:0]  k;
    w  = width_of(sel);
    n  = msg_q.size();
    nb = (n == 0) ? 1 : (n + w - 1) / w;
    for (int b = 0; b < nb; b++) begin
      if (gaps && $urandom_range(0, 3) == 0) tick();
      d = {$urandom, $urandom};
      k = '0;
      for (int j = 0; j < w; j++) begin
        if (b * w + j < n) begin
          d[8*j +: 8] = msg_q[b*w+j];
          k[j] = 1'b1;
        end
      end
      drive_beat(sel, d, k, b == nb - 1, start_first && b == 0);
    end
    chk($sformatf("%s_w%0d_valid", name, w), {31'd0, vld_o[sel]}, 32'd1);
    chk($sformatf("%s_w%0d_crc", name, w), crc_o[sel], exp_crc);
    chk($sformatf("%s_w%0d_isize", name, w), isz_o[sel], exp_isz);
  endtask

  task automatic release_result(input int sel, input int hold, input bit strict);
    logic [31:0] c;
    c = crc_o[sel];
    crc_ready_in = 1'b0;
    for (int h = 0; h < hold; h++) begin
      tick();
      if (strict) begin
        chk("hold_valid", {31'd0, vld_o[sel]}, 32'd1);
        chk("hold_crc", crc_o[sel], c);
        chk("hold_ready", {31'd0, rdy_o[sel]}, 32'd0);
      end
    end
    crc_ready_in = 1'b1;
    tick();
    chk("release_valid", {31'd0, vld_o[sel]}, 32'd0);
    chk("release_ready", {31'd0, rdy_o[sel]}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c, e;
    int sel, len;

    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      tbl[i] = c;
    end

    vecs[0] = '{"0123456789", 32'hA684_C7C6, 32'd10};
    vecs[1] = '{"123456789", 32'hCBF4_3926, 32'd9};
    vecs[2] = '{"The quick brown fox jumps over the lazy dog", 32'h414F_A339, 32'd43};
    vecs[3] = '{"", 32'h0000_0000, 32'd0};
    vecs[4] = '{"a", 32'hE8B7_BE43, 32'd1};

    rst_n = 1'b0;
    crc_start = 1'b0;
    data_last = 1'b0;
    crc_ready_in = 1'b1;
    din = '0;
    keep = '0;
    for (int s = 0; s < 3; s++) dvalid[s] = 1'b0;
    tick();
    tick();
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("reset_ready_%0d", s), {31'd0, rdy_o[s]}, 32'd0);
      chk($sformatf("reset_valid_%0d", s), {31'd0, vld_o[s]}, 32'd0);
      chk($sformatf("reset_crc_%0d", s), crc_o[s], 32'd0);
      chk($sformatf("reset_isize_%0d", s), isz_o[s], 32'd0);
    end
    rst_n = 1'b1;
    tick();
    for (int s = 0; s < 3; s++) chk($sformatf("ready_after_reset_%0d", s), {31'd0, rdy_o[s]}, 32'd1);

    for (int v = 0; v < 5; v++) begin
      for (int s = 0; s < 3; s++) begin
        load_str(vecs[v].msg);
        send_msg(s, 1'b0, 1'b0, vecs[v].crc, vecs[v].isize, $sformatf("vec%0d", v));
        release_result(s, 0, 1'b0);
      end
    end

    msg_q.delete();
    for (int i = 0; i < 32; i++) msg_q.push_back(8'h00);
    send_msg(1, 1'b0, 1'b0, 32'h190A_55AD, 32'd32, "zeros");
    release_result(1, 0, 1'b0);
    crc_start = 1'b1;
    tick();
    crc_start = 1'b0;
    msg_q.delete();
    for (int i = 0; i < 32; i++) msg_q.push_back(8'hFF);
    send_msg(1, 1'b0, 1'b0, 32'hFF6C_AB0B, 32'd32, "ones");
    release_result(1, 0, 1'b0);
    msg_q.delete();
    for (int i = 0; i < 32; i++) msg_q.push_back(8'(i));
    send_msg(1, 1'b0, 1'b0, 32'h9126_7E8A, 32'd32, "ramp");
    release_result(1, 0, 1'b0);

    load_str("0123456789");
    send_msg(1, 1'b0, 1'b0, 32'hA684_C7C6, 32'd10, "pre_hold");
    release_result(1, 5, 1'b1);
    load_str("123456789");
    send_msg(1, 1'b0, 1'b0, 32'hCBF4_3926, 32'd9, "post_hold");
    release_result(1, 0, 1'b0);

    // Abort after three beats, then the whole message again.
    drive_beat(1, 64'h3332_3130, 8'hF, 1'b0, 1'b0);
    drive_beat(1, 64'h3736_3534, 8'hF, 1'b0, 1'b0);
    drive_beat(1, 64'h0000_3938, 8'hF, 1'b0, 1'b0);
    crc_start = 1'b1;
    tick();
    crc_start = 1'b0;
    chk("abort_valid", {31'd0, vld_o[1]}, 32'd0);
    chk("abort_ready", {31'd0, rdy_o[1]}, 32'd1);
    load_str("0123456789");
    send_msg(1, 1'b0, 1'b0, 32'hA684_C7C6, 32'd10, "after_abort");
    release_result(1, 0, 1'b0);
    load_str("");
    send_msg(1, 1'b0, 1'b0, 32'h0, 32'd0, "keep_zero");
    release_result(1, 0, 1'b0);

    // crc_start on the same edge as the first beat of the new message.
    drive_beat(1, 64'hDEAD_BEEF, 8'hF, 1'b0, 1'b0);
    drive_beat(1, 64'h1234_5678, 8'hF, 1'b0, 1'b0);
    load_str("123456789");
    send_msg(1, 1'b0, 1'b1, 32'hCBF4_3926, 32'd9, "start_with_beat");
    release_result(1, 0, 1'b0);

    // Asynchronous reset in the middle of a message.
    drive_beat(1, 64'h3332_3130, 8'hF, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset_ready", {31'd0, rdy_o[1]}, 32'd0);
    chk("midreset_valid", {31'd0, vld_o[1]}, 32'd0);
    chk("midreset_isize", isz_o[1], 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("midreset_ready_back", {31'd0, rdy_o[1]}, 32'd1);
    load_str("0123456789");
    send_msg(1, 1'b0, 1'b0, 32'hA684_C7C6, 32'd10, "after_reset");

    // Asynchronous reset while a result is held.
    crc_ready_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("donereset_valid", {31'd0, vld_o[1]}, 32'd0);
    chk("donereset_crc", crc_o[1], 32'd0);
    chk("donereset_isize", isz_o[1], 32'd0);
    rst_n = 1'b1;
    crc_ready_in = 1'b1;
    tick();
    chk("donereset_ready_back", {31'd0, rdy_o[1]}, 32'd1);

    for (int r = 0; r < 30; r++) begin
      sel = int'($urandom_range(0, 2));
      len = int'($urandom_range(0, 40));
      msg_q.delete();
      for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
      e = ref_crc();
      send_msg(sel, 1'b1, 1'b0, e, 32'(len), $sformatf("rand%0d", r));
      release_result(sel, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
